// File: rtl/parq_meter_ctrl.sv
// Parking meter sequencer: turns coin pulses into saturating counter loads, paces the countdown, flags expiry.
// Optional grace period between zero credit and expiry is built in when PARQ_GRACE_EN is defined.
module parq_meter_ctrl #(
    parameter int W            = 8,
    parameter int TICK_DIV     = 50000000,
    parameter int COIN_A_UNITS = 10,
    parameter int COIN_B_UNITS = 25,
    parameter int GRACE_TICKS  = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_coin_a,
    input  logic         i_coin_b,
    input  logic         i_cancel,
    input  logic [W-1:0] i_cnt_q,
    input  logic         i_cnt_min_tick,
    input  logic         i_cnt_max_tick,
    output logic         o_cnt_syn_clr,
    output logic         o_cnt_load,
    output logic         o_cnt_en,
    output logic         o_cnt_up,
    output logic [W-1:0] o_cnt_d,
    output logic         o_active,
    output logic         o_expired,
    output logic         o_busy
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [W+3:0] A_UNITS = (W+4)'(COIN_A_UNITS);
    localparam logic [W+3:0] B_UNITS = (W+4)'(COIN_B_UNITS);
    localparam logic [W+3:0] SAT_MAX = (W+4)'({W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
`ifdef PARQ_GRACE_EN
        S_GRACE   = 2'd2,
`endif
        S_EXPIRED = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_settle;
    logic [1:0]    r_pend_a;
    logic [1:0]    r_pend_b;
    logic [PW-1:0] r_presc;
    logic          r_tick_pend;

    logic          w_clr;
    logic          w_load;
    logic          w_en;
    logic          w_tick_used;
    logic          w_pend_any;
    logic          w_running;
    logic          w_enter_count;
    logic [W+3:0]  w_sum;
    logic [W-1:0]  w_load_val;
    logic          w_unused;

`ifdef PARQ_GRACE_EN
    localparam int GW = (GRACE_TICKS > 1) ? $clog2(GRACE_TICKS) : 1;
    logic [GW-1:0] r_grace_cnt;
`endif

    // Max-tick is informational only; the saturating add already bounds every load.
    assign w_unused = i_cnt_max_tick | (GRACE_TICKS < 0);

    function automatic logic [1:0] f_sat_inc(input logic [1:0] v, input logic inc);
        return (inc && v != 2'd3) ? v + 2'd1 : v;
    endfunction

    assign w_pend_any = |{r_pend_a, r_pend_b};
    assign w_sum      = (W+4)'(i_cnt_q) + (W+4)'(r_pend_a) * A_UNITS + (W+4)'(r_pend_b) * B_UNITS;
    assign w_load_val = (w_sum > SAT_MAX) ? {W{1'b1}} : w_sum[W-1:0];

`ifdef PARQ_GRACE_EN
    assign w_running = (r_state == S_COUNT) || (r_state == S_GRACE);
`else
    assign w_running = (r_state == S_COUNT);
`endif
    assign w_enter_count = (w_next_state == S_COUNT) && (r_state != S_COUNT);

    // Command arbitration: cancel, then coin load, then countdown; SETTLE blocks all but cancel.
    always_comb begin
        // NOTE: every signal driven here gets a default first, otherwise a missed branch infers a latch.
        w_next_state = r_state;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_tick_used  = 1'b0;
        if (i_cancel) begin
            w_clr        = 1'b1;
            w_next_state = S_IDLE;
        end else if (!r_settle) begin
            if (w_pend_any) begin
                w_load       = 1'b1;
                w_next_state = S_COUNT;
            end else begin
                case (r_state)
                    S_COUNT: begin
                        if (i_cnt_min_tick) begin
`ifdef PARQ_GRACE_EN
                            w_next_state = S_GRACE;
`else
                            w_next_state = S_EXPIRED;
`endif
                        end else if (r_tick_pend) begin
                            w_en        = 1'b1;
                            w_tick_used = 1'b1;
                        end
                    end
`ifdef PARQ_GRACE_EN
                    S_GRACE: begin
                        if (r_tick_pend) begin
                            w_tick_used = 1'b1;
                            if (r_grace_cnt == GW'(GRACE_TICKS - 1)) w_next_state = S_EXPIRED;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_cnt_syn_clr = !i_reset || w_clr;
    assign o_cnt_load    = i_reset && w_load;
    assign o_cnt_en      = i_reset && w_en;
    assign o_cnt_up      = 1'b0;
    assign o_cnt_d       = (i_reset && w_load) ? w_load_val : '0;
    assign o_busy        = i_reset && (w_clr || w_load || w_en || r_settle);
    assign o_active      = i_reset && (w_load || (w_running && !w_clr));
    assign o_expired     = i_reset && (r_state == S_EXPIRED) && !w_load && !w_clr;

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_settle    <= 1'b0;
            r_pend_a    <= 2'd0;
            r_pend_b    <= 2'd0;
            r_presc     <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_settle <= w_clr || w_load || w_en;

            // A coin arriving in the load cycle is kept; one arriving with cancel is dropped.
            if (w_clr) begin
                r_pend_a <= 2'd0;
                r_pend_b <= 2'd0;
            end else if (w_load) begin
                r_pend_a <= {1'b0, i_coin_a};
                r_pend_b <= {1'b0, i_coin_b};
            end else begin
                r_pend_a <= f_sat_inc(r_pend_a, i_coin_a);
                r_pend_b <= f_sat_inc(r_pend_b, i_coin_b);
            end

            if (w_clr || w_enter_count) begin
                r_presc     <= '0;
                r_tick_pend <= 1'b0;
            end else if (w_running) begin
                if (r_presc == PW'(TICK_DIV - 1)) begin
                    r_presc     <= '0;
                    r_tick_pend <= 1'b1;
                end else begin
                    r_presc     <= r_presc + PW'(1);
                    r_tick_pend <= r_tick_pend && !w_tick_used;
                end
            end
        end
    end

`ifdef PARQ_GRACE_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_grace_cnt <= '0;
        end else if (r_state == S_GRACE && w_next_state == S_GRACE) begin
            r_grace_cnt <= r_grace_cnt + GW'(w_tick_used);
        end else begin
            r_grace_cnt <= '0;
        end
    end
`endif

endmodule
